alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, width-parametrised ALU for the multi-cycle CPU datapath. It keeps the single-cycle ALU's operand-select and flag behaviour, and adds an opcode set with shifts, compares, iterative multiply and unsigned divide/remainder. Operations enter and leave through valid/ready handshakes, so the control FSM can stall on long operations. It sits between the register-file read stage and the writeback mux.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width. Must be a power of two and at least 8.
- `CNT_W`, default `$clog2(WIDTH)`: iteration counter width. Derived; not overridden.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: operation request.
- `in_ready`  out  1: block can accept a request.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: register operand B.
- `imm_ext`  in  WIDTH: extended immediate.
- `alu_src`  in  1: operand B select; 1 selects `imm_ext`, 0 selects `b`.
- `alu_op`  in  4: opcode.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes the result.
- `res`  out  WIDTH: registered result.
- `zero`  out  1: `res == 0`, registered together with `res`.
- `illegal`  out  1: opcode was unassigned.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 XOR, 3 NOR, 4 OR. These are the legacy 3-bit codes, zero-extended.
  - 5 AND, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA.
  - 11 MUL, 12 DIVU, 13 REMU.
  - 14 and 15 are illegal.
- Operands and `alu_op` are captured on acceptance (`in_valid && in_ready`). Inputs are don't-care at all other times.
- Single-cycle ops: 0–10 and 14–15.
- Multi-cycle ops: 11–13.
- State machine:
  - IDLE: `in_ready=1`.
    - Accept single-cycle op: compute, register the result, go to DONE.
    - Accept multi-cycle op: go to BUSY.
  - BUSY: one iteration per cycle for WIDTH cycles. The counter loads WIDTH-1 and decrements. At 0, register the result and go to DONE.
  - DONE: `out_valid=1`. On `out_ready`, go to IDLE.
- Arithmetic rules:
  - ADD, SUB and MUL wrap modulo 2^WIDTH. MUL returns the low WIDTH bits and uses shift-add.
  - SLT and SLTU return 1 or 0 in bit 0, with upper bits zero.
  - Shift amount is `opB[CNT_W-1:0]`; upper bits are ignored. SRA replicates the sign bit.
  - DIVU/REMU use restoring division.
  - Divide by zero: DIVU returns all ones; REMU returns the dividend. The full WIDTH cycles are still taken.
  - Illegal op: `res=0`, `zero=1`, `illegal=1`. Legal ops clear `illegal`.
- `res`, `zero` and `illegal` hold their value until the next result is registered.

## Timing
- Reset (asynchronous, `rst_n` low):
  - State becomes IDLE and the counter clears.
  - `in_ready=1`, `out_valid=0`, `res=0`, `zero=1`, `illegal=0`.
- Reset mid-operation aborts the operation. No result is produced afterwards.
- Latency, with acceptance at edge T:
  - Single-cycle op: `out_valid` rises after edge T+1.
  - Multi-cycle op: `out_valid` rises after edge T+WIDTH+1.
- Handshake:
  - `in_ready` is low in BUSY and DONE. There is no overlap and no bypass.
  - `out_valid`, once high, stays high with a stable `res` until `out_ready` is sampled high.
  - After the output handshake at edge U, `in_ready=1` from U onward; the next acceptance is earliest at edge U+1.
- `out_ready` may already be high before DONE is entered. The result is then consumed on the first DONE edge, giving a 1-cycle `out_valid` pulse.
- Sustained throughput:
  - Single-cycle ops: 1 op per 2 cycles.
  - Multi-cycle ops: 1 op per WIDTH+2 cycles.

## Structure
- Package `alu_pkg` holds:
  - Opcode localparams (`ALU_ADD` … `ALU_REMU`).
  - The `is_multicycle(op)` function.
  - The state enum `alu_state_t` {IDLE, BUSY, DONE}.
- Sub-module `alu_muldiv` holds the shared iterative datapath:
  - Accumulator/remainder register, shifted multiplicand/quotient register, counter.
  - Interface: start, op select, operands, done, result.
- `alu_mc` holds the handshake FSM, the combinational single-cycle unit and the output registers.

## Test plan
All values use WIDTH=32.
- ADD, `a=5`, `imm_ext=7`, `alu_src=1`, `out_ready=1` -> `res=12`, `zero=0`, `out_valid` exactly 1 cycle after acceptance.
- SUB 9−9 -> `res=0`, `zero=1`; SLT −1 vs 1 -> 1; SLTU −1 vs 1 -> 0; SRA 0x8000_0000 by 36 -> 0xF800_0000 (shift 4).
- MUL 0xFFFF_FFFF×3 -> 0xFFFF_FFFD; `out_valid` at acceptance+33; `in_ready` low for all 33 cycles.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFF_FFFF; REMU 5/0 -> 5. Each has latency 33.
- Backpressure: `out_ready` held low for 4 cycles in DONE -> `res` stable and `in_ready` low; second op accepted 1 cycle after the handshake.
- `rst_n` pulsed low 10 cycles into a DIVU -> `out_valid=0`, `res=0`, `in_ready=1` immediately. Opcode 14 -> `res=0`, `illegal=1`.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and op classification shared by alu_mc
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;
  localparam logic [3:0] ALU_DIVU = 4'd12;
  localparam logic [3:0] ALU_REMU = 4'd13;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;

  // MUL, DIVU and REMU run on the iterative datapath; everything else is one cycle
  function automatic logic is_multicycle(input logic [3:0] op);
    return op == ALU_MUL || op == ALU_DIVU || op == ALU_REMU;
  endfunction
endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: shared iterative shift-add multiplier and restoring divider
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res
);
  // r_acc: product accumulator / partial remainder
  // r_q:   multiplier shifting right / dividend shifting out while quotient shifts in
  // r_x:   multiplicand shifting left / constant divisor
  logic [WIDTH-1:0] r_acc, r_q, r_x;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic             r_busy;
  logic [WIDTH:0]   w_trial, w_diff;
  logic [WIDTH-1:0] w_acc_n, w_q_n, w_x_n;
  logic             w_mul;

  assign w_mul   = r_op == ALU_MUL;
  assign w_trial = {r_acc, r_q[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_x};
  assign o_done  = r_busy && r_cnt == '0;
  assign o_res   = r_op == ALU_DIVU ? w_q_n : w_acc_n;

  // One iteration: add-and-shift for MUL, trial subtract with restore for DIVU/REMU.
  // A zero divisor never borrows, so the quotient fills with ones and the remainder ends as the dividend.
  always_comb begin
    w_acc_n = w_mul ? r_acc + (r_q[0] ? r_x : '0)
                    : (w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0]);
    w_q_n   = w_mul ? r_q >> 1 : {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
    w_x_n   = w_mul ? r_x << 1 : r_x;
  end

  // Load operands on start, then step once per cycle until the counter reaches zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_q    <= '0;
      r_x    <= '0;
      r_cnt  <= '0;
      r_op   <= ALU_ADD;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_acc  <= '0;
      r_q    <= i_op == ALU_MUL ? i_b : i_a;
      r_x    <= i_op == ALU_MUL ? i_a : i_b;
      r_cnt  <= CNT_W'(WIDTH - 1);
      r_op   <= i_op;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc  <= w_acc_n;
      r_q    <= w_q_n;
      r_x    <= w_x_n;
      r_cnt  <= r_cnt - CNT_W'(r_cnt != '0);
      r_busy <= r_cnt != '0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes and an iterative mul/div unit
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic             alu_src,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             illegal
);
  alu_state_t       r_state;
  logic             r_in_ready, r_out_valid, r_zero, r_illegal;
  logic [WIDTH-1:0] r_res, w_opb, w_res, w_md_res;
  logic [CNT_W-1:0] w_sh;
  logic             w_accept, w_multi, w_illegal, w_md_done;

  assign w_opb     = alu_src ? imm_ext : b;
  assign w_sh      = w_opb[CNT_W-1:0];
  assign w_accept  = in_valid && r_in_ready;
  assign w_multi   = is_multicycle(alu_op);
  assign w_illegal = alu_op[3:1] == 3'b111;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

  alu_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(w_accept && w_multi),
    .i_op   (alu_op),
    .i_a    (a),
    .i_b    (w_opb),
    .o_done (w_md_done),
    .o_res  (w_md_res)
  );

  // Single-cycle unit; multi-cycle and unassigned opcodes yield zero here
  always_comb begin
    case (alu_op)
      ALU_ADD:  w_res = a + w_opb;
      ALU_SUB:  w_res = a - w_opb;
      ALU_XOR:  w_res = a ^ w_opb;
      ALU_NOR:  w_res = ~(a | w_opb);
      ALU_OR:   w_res = a | w_opb;
      ALU_AND:  w_res = a & w_opb;
      ALU_SLT:  w_res = WIDTH'($signed(a) < $signed(w_opb));
      ALU_SLTU: w_res = WIDTH'(a < w_opb);
      ALU_SLL:  w_res = a << w_sh;
      ALU_SRL:  w_res = a >> w_sh;
      ALU_SRA:  w_res = WIDTH'($signed(a) >>> w_sh);
      default:  w_res = '0;
    endcase
  end

  // Handshake FSM with registered handshake outputs and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_zero      <= 1'b1;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_in_ready <= 1'b0;
          if (w_multi) r_state <= BUSY;
          else begin
            r_res       <= w_res;
            r_zero      <= w_res == '0;
            r_illegal   <= w_illegal;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        BUSY: if (w_md_done) begin
          r_res       <= w_md_res;
          r_zero      <= w_md_res == '0;
          r_illegal   <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector self-checking bench for alu_mc at WIDTH=32
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, alu_src = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] a = '0, b = '0, imm_ext = '0, res;
  logic [3:0]  alu_op = '0;
  int          n_checks = 0, n_errors = 0;
  logic [31:0] o_res;
  logic        o_zero, o_ill;
  int          o_lat, o_low, n_late;

  alu_mc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .imm_ext  (imm_ext),
    .alu_src  (alu_src),
    .alu_op   (alu_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .zero     (zero),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble inputs after acceptance, wait for out_valid, capture result
  task automatic run(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] iv, input logic src);
    alu_op = op; a = av; b = bv; imm_ext = iv; alu_src = src; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = $urandom; b = $urandom; imm_ext = $urandom; alu_op = 4'($urandom);
    alu_src = 1'($urandom);
    o_lat = 1;
    o_low = int'(!in_ready);
    while (!out_valid && o_lat < 100) begin
      step();
      o_lat++;
      o_low += int'(!in_ready);
    end
    o_res = res; o_zero = zero; o_ill = illegal;
    if (out_ready) step();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_zero", zero, 1);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    step();

    run(ALU_ADD, 5, 99, 7, 1);
    chk("add_res", o_res, 12); chk("add_zero", o_zero, 0); chk("add_lat", o_lat, 1);
    chk("add_ready_after", in_ready, 1); chk("add_valid_after", out_valid, 0);
    run(ALU_SUB, 9, 9, 0, 0);
    chk("sub_res", o_res, 0); chk("sub_zero", o_zero, 1);
    run(ALU_SLT, 32'hFFFF_FFFF, 1, 0, 0);   chk("slt", o_res, 1);
    run(ALU_SLTU, 32'hFFFF_FFFF, 1, 0, 0);  chk("sltu", o_res, 0);
    run(ALU_SRA, 32'h8000_0000, 0, 36, 1);  chk("sra", o_res, 32'hF800_0000);
    run(ALU_SRL, 32'h8000_0000, 36, 0, 0);  chk("srl", o_res, 32'h0800_0000);
    run(ALU_SLL, 1, 36, 0, 0);              chk("sll", o_res, 32'h10);
    run(ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0); chk("xor", o_res, 32'h0FF0_0FF0);
    run(ALU_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0); chk("or",  o_res, 32'hFFF0_FFF0);
    run(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0); chk("and", o_res, 32'hF000_F000);
    run(ALU_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0); chk("nor", o_res, 32'h000F_000F);

    run(ALU_MUL, 32'hFFFF_FFFF, 3, 0, 0);
    chk("mul_res", o_res, 32'hFFFF_FFFD); chk("mul_lat", o_lat, 33); chk("mul_ready_low", o_low, 33);
    chk("mul_illegal", o_ill, 0);
    run(ALU_MUL, 1234, 0, 5678, 1);         chk("mul_imm", o_res, 32'h006A_E9BC);
    run(ALU_DIVU, 100, 7, 0, 0);
    chk("divu_res", o_res, 14); chk("divu_lat", o_lat, 33);
    run(ALU_REMU, 100, 7, 0, 0);
    chk("remu_res", o_res, 2); chk("remu_lat", o_lat, 33);
    run(ALU_DIVU, 5, 0, 0, 0);
    chk("divu0_res", o_res, 32'hFFFF_FFFF); chk("divu0_lat", o_lat, 33);
    run(ALU_REMU, 5, 0, 0, 0);
    chk("remu0_res", o_res, 5); chk("remu0_lat", o_lat, 33);
    run(ALU_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0); chk("divu_big", o_res, 1);
    run(ALU_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0); chk("remu_big", o_res, 32'h7FFF_FFFF);
    run(ALU_REMU, 0, 0, 0, 0); chk("remu_zero_res", o_res, 0); chk("remu_zero_flag", o_zero, 1);

    out_ready = 1'b0;
    alu_op = ALU_ADD; a = 3; b = 4; alu_src = 1'b0; in_valid = 1'b1;
    step();
    chk("bp_valid", out_valid, 1);
    a = 20; b = 22;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_res_hold", res, 7); chk("bp_valid_hold", out_valid, 1); chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_hs_valid", out_valid, 0); chk("bp_hs_ready", in_ready, 1); chk("bp_hs_res", res, 7);
    step();
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1); chk("bp_second_res", res, 42);
    step();

    alu_op = ALU_DIVU; a = 100; b = 7; alu_src = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("rst_mid_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0); chk("rst_mid_res", res, 0); chk("rst_mid_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    n_late = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n_late += int'(out_valid);
    end
    chk("rst_mid_no_result", n_late, 0);

    run(ALU_ADD, 1, 1, 0, 0);       chk("pre_ill_res", o_res, 2);
    run(4'd14, 1, 1, 0, 0);
    chk("ill14_res", o_res, 0); chk("ill14_zero", o_zero, 1); chk("ill14_flag", o_ill, 1);
    chk("ill14_hold", illegal, 1);
    run(4'd15, 7, 7, 0, 0);         chk("ill15_flag", o_ill, 1);
    run(ALU_OR, 0, 6, 0, 0);
    chk("legal_clears", o_ill, 0); chk("legal_res", o_res, 6);
    run(4'd14, 1, 1, 0, 0);
    run(ALU_MUL, 2, 3, 0, 0);
    chk("mul_clears_ill", o_ill, 0); chk("mul_small", o_res, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
